// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one simple_bus memory target between
// N_MASTERS requesters; muxes the owner's request and times out stalled reads.

module simple_bus_arbiter_lane #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MODE_W = 2
) (
  input  logic              sel_i,
  input  logic              done_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [MODE_W-1:0] mode_o,
  output logic              rdy_o
);
  // AND-gated so the top can OR all lanes into the shared bus
  assign addr_o  = sel_i ? addr_i  : '0;
  assign wdata_o = sel_i ? wdata_i : '0;
  assign mode_o  = sel_i ? mode_i  : '0;
  assign rdy_o   = sel_i & done_i;
endmodule

module simple_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MODE_W    = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*MODE_W-1:0]   m_mode,
  output logic [N_MASTERS-1:0]          m_gnt,
  output logic [N_MASTERS-1:0]          m_rdy,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_start,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [MODE_W-1:0]             s_mode,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rdy,
  output logic                          busy,
  output logic [$clog2(N_MASTERS)-1:0]  owner,
  output logic                          timeout_err
);
  localparam int OW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [OW:0]   NM      = (OW+1)'(N_MASTERS);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [OW-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic                   found;
  logic [OW-1:0]          pick, ptr_nxt;
  logic [OW:0]            sum, inc;

  // Rotating priority scan starting at ptr_q
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      sum = {1'b0, ptr_q} + (OW+1)'(k);
      if (sum >= NM) sum = sum - NM;
      if (!found && m_req[sum[OW-1:0]]) begin
        found = 1'b1;
        pick  = sum[OW-1:0];
      end
    end
  end

  always_comb begin
    inc = {1'b0, owner_q} + (OW+1)'(1);
    if (inc >= NM) inc = '0;
    ptr_nxt = inc[OW-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d     = pick;
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        state_d     = START;
      end
      START: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response in the final allowed cycle beats the timeout
        if (s_rdy) begin
          rdata_d = s_rdata;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign s_start     = (state_q == START);
  assign timeout_err = (state_q == DONE) & err_q;
  assign m_gnt       = gnt_q;
  assign m_rdata     = rdata_q;
  assign owner       = owner_q;

  logic [N_MASTERS-1:0][ADDR_W-1:0] lane_addr;
  logic [N_MASTERS-1:0][DATA_W-1:0] lane_wdata;
  logic [N_MASTERS-1:0][MODE_W-1:0] lane_mode;
  logic [N_MASTERS-1:0]             lane_rdy;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    simple_bus_arbiter_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE_W(MODE_W)) u_lane (
      .sel_i   (busy && (owner_q == OW'(i))),
      .done_i  (state_q == DONE),
      .addr_i  (m_addr[i*ADDR_W +: ADDR_W]),
      .wdata_i (m_wdata[i*DATA_W +: DATA_W]),
      .mode_i  (m_mode[i*MODE_W +: MODE_W]),
      .addr_o  (lane_addr[i]),
      .wdata_o (lane_wdata[i]),
      .mode_o  (lane_mode[i]),
      .rdy_o   (lane_rdy[i])
    );
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_mode  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      s_addr  = s_addr  | lane_addr[i];
      s_wdata = s_wdata | lane_wdata[i];
      s_mode  = s_mode  | lane_mode[i];
    end
  end

  assign m_rdy = lane_rdy;
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Scoreboard bench for simple_bus_arbiter: expected transactions are queued as
// requests are raised and retired against m_rdy; a small memory model answers.

module tb_simple_bus_arbiter;
  localparam int N = 4, AW = 8, DW = 8, MW = 2, TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_gnt, m_rdy;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*MW-1:0] m_mode;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic [MW-1:0]   s_mode;
  logic            s_start, s_rdy, busy, timeout_err;
  logic [1:0]      owner;

  simple_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MODE_W(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
    .m_gnt(m_gnt), .m_rdy(m_rdy), .m_rdata(m_rdata), .s_start(s_start), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_mode(s_mode), .s_rdata(s_rdata), .s_rdy(s_rdy), .busy(busy),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   own;
    logic [7:0]   addr;
    logic [7:0]   wdata;
    logic [1:0]   mode;
    logic [7:0]   rdata;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0, cyc = 0, st_cyc = 0, mem_lat = 1;
  int   rem[N];
  bit   in_txn = 1'b0;
  logic [7:0] mem_a;

  function automatic logic [7:0] addr_of(int i);  return 8'(12 + 48 * i);  endfunction
  function automatic logic [7:0] wdata_of(int i); return 8'(8'h81 + i);    endfunction
  function automatic logic [1:0] mode_of(int i);  return 2'(3 - i);        endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(int m, int lat);
    exp_t x;
    x.gnt   = N'(1) << m;
    x.own   = 2'(m);
    x.addr  = addr_of(m);
    x.wdata = wdata_of(m);
    x.mode  = mode_of(m);
    x.err   = (lat == 0);
    x.rdata = x.err ? 8'hFF : (addr_of(m) ^ 8'h99);
    x.cyc   = x.err ? TO + 1 : lat + 1;
    q.push_back(x);
  endtask

  task automatic check_zero(string pfx);
    chk({pfx, "_gnt"}, m_gnt, 0);
    chk({pfx, "_rdy"}, m_rdy, 0);
    chk({pfx, "_rdata"}, m_rdata, 0);
    chk({pfx, "_start"}, s_start, 0);
    chk({pfx, "_saddr"}, s_addr, 0);
    chk({pfx, "_swdata"}, s_wdata, 0);
    chk({pfx, "_smode"}, s_mode, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_owner"}, owner, 0);
    chk({pfx, "_terr"}, timeout_err, 0);
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while ((m_req != 0 || busy || q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drain", q.size(), 0);
    chk("req_drain", m_req, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic raise(int m);
    rem[m]++;
    m_req[m] = 1'b1;
  endtask

  // Memory: answers L cycles into WAIT (L = mem_lat), never when mem_lat == 0
  initial begin
    s_rdy = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (s_start && mem_lat > 0) begin
        mem_a = s_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        s_rdy = 1'b1;
        s_rdata = mem_a ^ 8'h99;
        @(posedge clk); #1;
        s_rdy = 1'b0;
        s_rdata = 8'h5A;
      end
    end
  end

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (s_start) begin
        chk("start_sb", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("s_addr", s_addr, q[0].addr);
          chk("s_wdata", s_wdata, q[0].wdata);
          chk("s_mode", s_mode, q[0].mode);
          chk("gnt_start", m_gnt, q[0].gnt);
          chk("owner_start", owner, q[0].own);
          in_txn = 1'b1;
          st_cyc = cyc;
        end
      end else if (in_txn && q.size() != 0) begin
        chk("gnt_hold", m_gnt, q[0].gnt);
        chk("busy_hold", busy, 1);
      end
      if (m_rdy != 0) begin
        chk("rdy_sb", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("m_rdy", m_rdy, e.gnt);
          chk("m_rdata", m_rdata, e.rdata);
          chk("timeout_err", timeout_err, e.err);
          chk("latency", cyc - st_cyc, e.cyc);
          chk("owner_done", owner, e.own);
          in_txn = 1'b0;
          for (int i = 0; i < N; i++)
            if (m_rdy[i]) begin
              rem[i]--;
              if (rem[i] <= 0) m_req[i] = 1'b0;
            end
        end
      end else if (timeout_err) begin
        chk("stray_terr", timeout_err, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_req = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      m_addr[i*AW +: AW]  = addr_of(i);
      m_wdata[i*DW +: DW] = wdata_of(i);
      m_mode[i*MW +: MW]  = mode_of(i);
    end
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read from master 1
    mem_lat = 1;
    expect_txn(1, 1);
    raise(1);
    wait_idle(100);

    // ptr=2 after master 1: 0b0101 serves 2 then 0
    expect_txn(2, 1); expect_txn(0, 1);
    raise(0); raise(2);
    wait_idle(100);

    // Wrap: master 2 leaves ptr=3, then 0b1001 serves 3 then 0
    expect_txn(2, 1);
    raise(2);
    wait_idle(100);
    expect_txn(3, 1); expect_txn(0, 1);
    raise(0); raise(3);
    wait_idle(100);

    // Master 3 returns ptr to 0, then full contention
    expect_txn(3, 1);
    raise(3);
    wait_idle(100);
    expect_txn(0, 1); expect_txn(1, 1); expect_txn(2, 1); expect_txn(3, 1); expect_txn(0, 1);
    raise(0); raise(0); raise(1); raise(2); raise(3);
    wait_idle(200);

    // Timeout then a normal follow-up
    mem_lat = 0;
    expect_txn(1, 0);
    raise(1);
    wait_idle(100);
    mem_lat = 1;
    expect_txn(2, 1);
    raise(2);
    wait_idle(100);

    // Late memory on the last allowed WAIT cycle
    mem_lat = 15;
    expect_txn(3, 15);
    raise(3);
    wait_idle(100);

    // Reset asserted mid-WAIT on master 2
    mem_lat = 0;
    expect_txn(2, 0);
    raise(2);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    q.delete();
    in_txn = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    expect_txn(2, 1);
    rst = 1'b0;
    wait_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
